// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the CP0 exception sequencer and its optional timer:
// CP0 register addresses, ExcCode values, Status bit positions, the sequencer
// state enum and small helpers that format the values written into CP0.
// -----------------------------------------------------------------------------
package cp0_pkg;

  // CP0 register numbers used by the sequencer and the timer
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // ExcCode values reported by the commit stage
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // Status bit positions
  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_EPC    = 3'd1,
    ST_W_BADV   = 3'd2,
    ST_W_CAUSE  = 3'd3,
    ST_W_STATUS = 3'd4,
    ST_E_STATUS = 3'd5,
    ST_REDIR    = 3'd6
  } exc_state_e;

  // EPC points at the branch when the faulting instruction sits in a delay slot
  function automatic logic [31:0] epc_value(input logic [31:0] pc, input logic bd);
    logic [31:0] v;
    if (bd) begin
      v = pc - 32'd4;
    end else begin
      v = pc;
    end
    return v;
  endfunction

  // Cause image: BD in bit 31, pending IP vector in [15:8], ExcCode in [6:2]
  function automatic logic [31:0] cause_value(input logic bd, input logic [7:0] ip,
                                              input logic [4:0] code);
    return {bd, 15'd0, ip, 1'b0, code, 2'd0};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
// Shadow of CP0 Count/Compare that produces the timer interrupt for IP[7].
// Count advances once every two clocks (first step on the first edge after
// reset). The interrupt is sticky once Count equals a non-zero Compare and is
// cleared by any write to Compare.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   wen/waddr/wdata    accepted MTC0 write (addr 9 loads Count, 11 loads Compare)
//   timer_int          sticky timer interrupt
// -----------------------------------------------------------------------------
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic        timer_int
);

  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        phase_r;
  logic        timer_int_r;

  // Count register: loaded by MTC0 Count, otherwise steps on every other edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= 32'd0;
      phase_r <= 1'b0;
    end else begin
      phase_r <= ~phase_r;
      if (wen && (waddr == CP0_COUNT)) begin
        count_r <= wdata;
      end else if (!phase_r) begin
        count_r <= count_r + 32'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Compare register and sticky interrupt; a Compare write wins over a match
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare_r   <= 32'd0;
      timer_int_r <= 1'b0;
    end else begin
      if (wen && (waddr == CP0_COMPARE)) begin
        compare_r   <= wdata;
        timer_int_r <= 1'b0;
      end else if ((count_r == compare_r) && (compare_r != 32'd0)) begin
        timer_int_r <= 1'b1;
      end else begin
        timer_int_r <= timer_int_r;
      end
    end
  end

  assign timer_int = timer_int_r;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl
// Exception / ERET / MTC0 sequencer between the commit stage and CP0. It
// accepts one request in IDLE (exception > ERET > MTC0), serializes the CP0
// writes through the single write port, flushes the pipeline on the accept
// cycle and issues a one-cycle redirect. It also derives int_req from
// Status/Cause and the hardware interrupt lines.
// Optional feature macro: CP0_TIMER_INT_EN (adds cp0_timer, drives IP[7]).
// Ports:
//   hw_int                 level hardware interrupts
//   exc_*/eret_valid/mtc0_* commit-stage requests, held until req_ready
//   status_in/cause_in/epc_in current CP0 contents
//   cp0_wen/waddr/wdata    CP0 general write port
//   flush, redirect_*      pipeline control
//   req_ready, busy, int_req status
// -----------------------------------------------------------------------------
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_has_bad,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret_valid,
  input  logic        mtc0_valid,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  output logic        req_ready,
  input  logic [31:0] status_in,
  input  logic [31:0] cause_in,
  input  logic [31:0] epc_in,
  output logic        cp0_wen,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        int_req,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  exc_state_e  state_r;
  exc_state_e  state_nxt_s;
  logic [7:0]  ip_s;
  logic        accept_exc_s;
  logic        accept_eret_s;
  logic        accept_mtc0_s;
  logic        unused_s;

  logic [4:0]  code_r;
  logic [31:0] pc_r;
  logic        bd_r;
  logic        has_bad_r;
  logic [31:0] badv_r;
  logic [7:0]  ip_r;
  logic [31:0] redir_pc_r;

`ifdef CP0_TIMER_INT_EN
  logic timer_int_s;

  cp0_timer u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .wen       (accept_mtc0_s),
    .waddr     (mtc0_addr),
    .wdata     (mtc0_data),
    .timer_int (timer_int_s)
  );

  assign ip_s     = {timer_int_s, hw_int[4:0], cause_in[9:8]};
  assign unused_s = ^{cause_in[31:10], cause_in[7:0], hw_int[5]};
`else
  assign ip_s     = {hw_int, cause_in[9:8]};
  assign unused_s = ^{cause_in[31:10], cause_in[7:0]};
`endif

  // Request arbitration: only in IDLE and outside reset; the flush kills the losers
  always_comb begin
    accept_exc_s  = 1'b0;
    accept_eret_s = 1'b0;
    accept_mtc0_s = 1'b0;
    if (resetn && (state_r == ST_IDLE)) begin
      accept_exc_s  = exc_valid;
      accept_eret_s = ~exc_valid & eret_valid;
      accept_mtc0_s = ~exc_valid & ~eret_valid & mtc0_valid;
    end else begin
      accept_exc_s  = 1'b0;
    end
  end

  // Interrupt request: enabled, not at exception level, and a pending unmasked line
  always_comb begin
    int_req = resetn & status_in[STATUS_IE_BIT] & ~status_in[STATUS_EXL_BIT]
              & (|(status_in[15:8] & ip_s));
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_exc_s) begin
          state_nxt_s = ST_W_EPC;
        end else if (accept_eret_s) begin
          state_nxt_s = ST_E_STATUS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_W_EPC: begin
        if (has_bad_r) begin
          state_nxt_s = ST_W_BADV;
        end else begin
          state_nxt_s = ST_W_CAUSE;
        end
      end
      ST_W_BADV:   state_nxt_s = ST_W_CAUSE;
      ST_W_CAUSE:  state_nxt_s = ST_W_STATUS;
      ST_W_STATUS: state_nxt_s = ST_REDIR;
      ST_E_STATUS: state_nxt_s = ST_REDIR;
      ST_REDIR:    state_nxt_s = ST_IDLE;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode; MTC0 passes straight through on its accept cycle
  always_comb begin
    req_ready      = 1'b0;
    busy           = 1'b1;
    flush          = 1'b0;
    cp0_wen        = 1'b0;
    cp0_waddr      = 5'd0;
    cp0_wdata      = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    case (state_r)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        flush     = accept_exc_s | accept_eret_s;
        if (accept_mtc0_s) begin
          cp0_wen   = 1'b1;
          cp0_waddr = mtc0_addr;
          cp0_wdata = mtc0_data;
        end else begin
          cp0_wen   = 1'b0;
        end
      end
      ST_W_EPC: begin
        cp0_wen   = 1'b1;
        cp0_waddr = CP0_EPC;
        cp0_wdata = epc_value(pc_r, bd_r);
      end
      ST_W_BADV: begin
        cp0_wen   = 1'b1;
        cp0_waddr = CP0_BADVADDR;
        cp0_wdata = badv_r;
      end
      ST_W_CAUSE: begin
        cp0_wen   = 1'b1;
        cp0_waddr = CP0_CAUSE;
        cp0_wdata = cause_value(bd_r, ip_r, code_r);
      end
      ST_W_STATUS: begin
        cp0_wen   = 1'b1;
        cp0_waddr = CP0_STATUS;
        cp0_wdata = status_in | (32'd1 << STATUS_EXL_BIT);
      end
      ST_E_STATUS: begin
        cp0_wen   = 1'b1;
        cp0_waddr = CP0_STATUS;
        cp0_wdata = status_in & ~(32'd1 << STATUS_EXL_BIT);
      end
      ST_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_pc_r;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Request snapshot taken on accept so later input changes cannot disturb the sequence
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      code_r     <= 5'd0;
      pc_r       <= 32'd0;
      bd_r       <= 1'b0;
      has_bad_r  <= 1'b0;
      badv_r     <= 32'd0;
      ip_r       <= 8'd0;
      redir_pc_r <= 32'd0;
    end else if (accept_exc_s) begin
      code_r     <= exc_code;
      pc_r       <= exc_pc;
      bd_r       <= exc_bd;
      has_bad_r  <= exc_has_bad;
      badv_r     <= exc_badvaddr;
      ip_r       <= ip_s;
      redir_pc_r <= EXC_VECTOR;
    end else if (accept_eret_s) begin
      redir_pc_r <= epc_in;
    end else begin
      redir_pc_r <= redir_pc_r;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_exc_ctrl
// Directed and randomized bench for cp0_exc_ctrl. A behavioural model turns
// each request into the list of CP0 writes plus the redirect target and the
// cycle-by-cycle outputs are compared against that list.
// -----------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

  localparam logic [31:0] EXC_VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_has_bad;
  logic [31:0] exc_badvaddr;
  logic        eret_valid;
  logic        mtc0_valid;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic        req_ready;
  logic [31:0] status_in;
  logic [31:0] cause_in;
  logic [31:0] epc_in;
  logic        cp0_wen;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        int_req;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  cp0_exc_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .hw_int         (hw_int),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_pc         (exc_pc),
    .exc_bd         (exc_bd),
    .exc_has_bad    (exc_has_bad),
    .exc_badvaddr   (exc_badvaddr),
    .eret_valid     (eret_valid),
    .mtc0_valid     (mtc0_valid),
    .mtc0_addr      (mtc0_addr),
    .mtc0_data      (mtc0_data),
    .req_ready      (req_ready),
    .status_in      (status_in),
    .cause_in       (cause_in),
    .epc_in         (epc_in),
    .cp0_wen        (cp0_wen),
    .cp0_waddr      (cp0_waddr),
    .cp0_wdata      (cp0_wdata),
    .int_req        (int_req),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // IP vector as seen by software: hw lines on [7:2], software bits from Cause[9:8]
  function automatic logic [7:0] ip_of(input logic [5:0] hw, input logic [31:0] cause);
    logic [31:0] v;
    v = (32'(hw) << 2) | ((cause >> 8) & 32'd3);
`ifdef CP0_TIMER_INT_EN
    v = v & 32'h7f;  // IP7 belongs to the (idle) timer in this build
`endif
    return v[7:0];
  endfunction

  function automatic logic int_of(input logic [31:0] st, input logic [7:0] ip);
    return (st[0] == 1'b1) && (st[1] == 1'b0) && (((st >> 8) & 32'hff & 32'(ip)) != 32'd0);
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_wen"}, 32'(cp0_wen), 32'd0);
    chk({tag, "_waddr"}, 32'(cp0_waddr), 32'd0);
    chk({tag, "_wdata"}, cp0_wdata, 32'd0);
    chk({tag, "_flush"}, 32'(flush), 32'd0);
    chk({tag, "_redir"}, 32'(redirect_valid), 32'd0);
    chk({tag, "_rpc"}, redirect_pc, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_int"}, 32'(int_req), 32'd0);
  endtask

  // Presents a request (fields already driven) and checks the whole response.
  // Called just after a rising edge with the DUT idle.
  task automatic run_txn(input string tag, input bit do_exc, input bit do_eret, input bit do_mtc0);
    logic [4:0]  wa[$];
    logic [31:0] wd[$];
    logic [31:0] redir;
    logic [31:0] st;
    logic [7:0]  ip_acc;
    int          n;
    int          last;
    bit          mtc0_wins;
    st     = status_in;
    ip_acc = ip_of(hw_int, cause_in);
    redir  = 32'd0;
    if (do_exc) begin
      wa.push_back(5'd14);
      wd.push_back(exc_bd ? exc_pc - 32'd4 : exc_pc);
      if (exc_has_bad) begin
        wa.push_back(5'd8);
        wd.push_back(exc_badvaddr);
      end
      wa.push_back(5'd13);
      wd.push_back((32'(exc_bd) << 31) | (32'(ip_acc) << 8) | (32'(exc_code) << 2));
      wa.push_back(5'd12);
      wd.push_back(st | 32'h2);
      redir = EXC_VEC;
    end else if (do_eret) begin
      wa.push_back(5'd12);
      wd.push_back(st & ~32'h2);
      redir = epc_in;
    end
    n         = wa.size();
    mtc0_wins = do_mtc0 && !do_exc && !do_eret;
    exc_valid  = do_exc;
    eret_valid = do_eret;
    mtc0_valid = do_mtc0;
    @(negedge clk);
    chk({tag, "_acc_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_acc_flush"}, 32'(flush), 32'(do_exc | do_eret));
    chk({tag, "_acc_wen"}, 32'(cp0_wen), 32'(mtc0_wins));
    if (mtc0_wins) begin
      chk({tag, "_acc_waddr"}, 32'(cp0_waddr), 32'(mtc0_addr));
      chk({tag, "_acc_wdata"}, cp0_wdata, mtc0_data);
    end
    chk({tag, "_acc_int"}, 32'(int_req), 32'(int_of(st, ip_acc)));
    @(posedge clk);
    #1;
    exc_valid  = 1'b0;
    eret_valid = 1'b0;
    mtc0_valid = 1'b0;
    hw_int     = 6'($urandom);
    cause_in   = $urandom;
    epc_in     = $urandom;
    last       = (n > 0) ? n + 2 : 1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      chk({tag, "_wen"}, 32'(cp0_wen), 32'(k <= n));
      if (k <= n) begin
        chk({tag, "_waddr"}, 32'(cp0_waddr), 32'(wa[k-1]));
        chk({tag, "_wdata"}, cp0_wdata, wd[k-1]);
      end
      chk({tag, "_redir"}, 32'(redirect_valid), 32'((n > 0) && (k == n + 1)));
      if ((n > 0) && (k == n + 1)) begin
        chk({tag, "_rpc"}, redirect_pc, redir);
      end
      chk({tag, "_busy"}, 32'(busy), 32'((n > 0) && (k <= n + 1)));
      chk({tag, "_ready"}, 32'(req_ready), 32'(!((n > 0) && (k <= n + 1))));
      chk({tag, "_flush"}, 32'(flush), 32'd0);
      chk({tag, "_int"}, 32'(int_req), 32'(int_of(status_in, ip_of(hw_int, cause_in))));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    hw_int = 6'd0; exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0;
    exc_has_bad = 1'b0; exc_badvaddr = 32'd0; eret_valid = 1'b0; mtc0_valid = 1'b0;
    mtc0_addr = 5'd0; mtc0_data = 32'd0; status_in = 32'd0; cause_in = 32'd0; epc_in = 32'd0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Exception with a bad address
    exc_code = 5'h04; exc_pc = 32'hBFC00100; exc_has_bad = 1'b1;
    exc_badvaddr = 32'h00000003; exc_bd = 1'b0; status_in = 32'h0000FF01;
    run_txn("exc_bad", 1'b1, 1'b0, 1'b0);

    // Delay-slot exception, no bad address
    exc_code = 5'h08; exc_pc = 32'h80001004; exc_has_bad = 1'b0; exc_bd = 1'b1;
    run_txn("exc_bd", 1'b1, 1'b0, 1'b0);

    // ERET
    epc_in = 32'h80002000; status_in = 32'h0000FF03;
    run_txn("eret", 1'b0, 1'b1, 1'b0);

    // MTC0 alone
    mtc0_addr = 5'd12; mtc0_data = 32'h12345678;
    run_txn("mtc0", 1'b0, 1'b0, 1'b1);

    // All three at once: exception wins
    exc_code = 5'h0c; exc_pc = 32'h80003000; exc_bd = 1'b0; exc_has_bad = 1'b0;
    status_in = 32'h0000FF01; mtc0_addr = 5'd13; mtc0_data = 32'hDEADBEEF;
    run_txn("all3", 1'b1, 1'b1, 1'b1);

    // Interrupt detection (combinational)
    hw_int = 6'b000001; cause_in = 32'd0; status_in = 32'h00000401;
    @(negedge clk);
    chk("int_hw0", 32'(int_req), 32'd1);
    status_in = 32'h00000403;
    #1;
    chk("int_exl", 32'(int_req), 32'd0);
    status_in = 32'h00000400;
    #1;
    chk("int_noie", 32'(int_req), 32'd0);
    hw_int = 6'd0; cause_in = 32'h00000100; status_in = 32'h00000101;
    #1;
    chk("int_sw0", 32'(int_req), 32'd1);
    status_in = 32'h00000201;
    #1;
    chk("int_masked", 32'(int_req), 32'd0);
    @(posedge clk);
    #1;

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      exc_code = 5'($urandom); exc_pc = $urandom; exc_bd = 1'($urandom);
      exc_has_bad = 1'($urandom); exc_badvaddr = $urandom; epc_in = $urandom;
      status_in = $urandom; cause_in = $urandom; hw_int = 6'($urandom);
      mtc0_addr = 5'($urandom_range(0, 7)); mtc0_data = $urandom;
      run_txn("rnd", (kind == 0) || (kind == 3), (kind == 1) || (kind == 3),
              (kind == 2) || (kind == 3));
    end

    // Reset while the Cause write is on the port
    exc_code = 5'h04; exc_pc = 32'h80004000; exc_bd = 1'b0; exc_has_bad = 1'b1;
    exc_badvaddr = 32'h00000010; status_in = 32'h0000FF01; hw_int = 6'b000001; cause_in = 32'd0;
    exc_valid = 1'b1;
    @(posedge clk);
    #1;
    exc_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_cause_addr", 32'(cp0_waddr), 32'd13);
    #1;
    resetn = 1'b0;
    #1;
    chk_quiet("mid_reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    hw_int = 6'd0;
    run_txn("after_reset", 1'b1, 1'b0, 1'b0);

`ifdef CP0_TIMER_INT_EN
    // Timer: Compare = 10 written right after reset, interrupt 20 cycles later
    resetn = 1'b0;
    hw_int = 6'd0; cause_in = 32'd0; status_in = 32'h00008001;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mtc0_addr = 5'd11; mtc0_data = 32'd10; mtc0_valid = 1'b1;
    for (int m = 1; m <= 22; m++) begin
      @(posedge clk);
      #1;
      mtc0_valid = 1'b0;
      @(negedge clk);
      chk("timer_rise", 32'(int_req), 32'(m >= 20));
    end
    @(posedge clk);
    #1;
    mtc0_addr = 5'd11; mtc0_data = 32'd0; mtc0_valid = 1'b1;
    @(posedge clk);
    #1;
    mtc0_valid = 1'b0;
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      chk("timer_clear", 32'(int_req), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
